// File: rtl/mcse_bus_pkg.sv
// Shared AHB encodings, FSM state type and beat/byte derivations for the bus front-end.
// Latency: none; constants and pure functions only.
// Backpressure: not applicable.
package mcse_bus_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BURST,
        ST_LAST,
        ST_ERR,
        ST_DONE
    } state_t;

    function automatic int calc_beats(input int payload_bits, input int data_bits);
        return payload_bits / data_bits;
    endfunction

    function automatic int calc_bytes(input int data_bits);
        return data_bits / 8;
    endfunction

endpackage

// File: rtl/mcse_rr_arbiter.sv
// Round-robin grant across N_REQ request levels; pointer moves past the last served channel.
// Latency: grant is combinational from req/pointer; pointer updates one cycle after upd.
// Backpressure: none; caller samples the grant only when it can accept a new request.
module mcse_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             upd,
    input  logic [IDX_W-1:0] upd_idx,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (int'(upd_idx) == N_REQ - 1) ? '0 : upd_idx + 1'b1;
        end
    end

    // Scan from the far end so the channel closest to the pointer wins.
    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mcse_bus_arbiter.sv
// Arbitrates payload-level clients onto one AHB requester port as aligned INCR bursts.
// Latency: req_go to req_done is BEATS+2 cycles with zero wait states; +1 per wait state.
// Backpressure: I_hready low stalls address and data phases; ERROR abandons the burst.
module mcse_bus_arbiter
    import mcse_bus_pkg::*;
#(
    parameter int N_REQ              = 2,
    parameter int pAHB_ADDR_WIDTH    = 32,
    parameter int pAHB_DATA_WIDTH    = 32,
    parameter int pPAYLOAD_SIZE_BITS = 256,
    parameter int pAHB_HRESP_WIDTH   = 2,
    parameter int pAHB_BURST_WIDTH   = 3,
    parameter int pAHB_PROT_WIDTH    = 4,
    parameter int pAHB_SIZE_WIDTH    = 3,
    parameter int pAHB_TRANS_WIDTH   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_REQ-1:0]                      req_go,
    input  logic [N_REQ*pAHB_ADDR_WIDTH-1:0]      req_addr,
    input  logic [N_REQ*pPAYLOAD_SIZE_BITS-1:0]   req_wdata,
    input  logic [N_REQ-1:0]                      req_rw,
    output logic [N_REQ-1:0]                      req_done,
    output logic [N_REQ-1:0]                      req_err,
    output logic [pPAYLOAD_SIZE_BITS-1:0]         req_rdata,
    input  logic [pAHB_DATA_WIDTH-1:0]            I_hrdata,
    input  logic                                  I_hready,
    input  logic [pAHB_HRESP_WIDTH-1:0]           I_hresp,
    output logic [pAHB_ADDR_WIDTH-1:0]            O_haddr,
    output logic [pAHB_BURST_WIDTH-1:0]           O_hburst,
    output logic                                  O_hmastlock,
    output logic [pAHB_PROT_WIDTH-1:0]            O_hprot,
    output logic                                  O_hnonsec,
    output logic [pAHB_SIZE_WIDTH-1:0]            O_hsize,
    output logic [pAHB_TRANS_WIDTH-1:0]           O_htrans,
    output logic [pAHB_DATA_WIDTH-1:0]            O_hwdata,
    output logic                                  O_hwrite
);

    localparam int AW     = pAHB_ADDR_WIDTH;
    localparam int DW     = pAHB_DATA_WIDTH;
    localparam int PW     = pPAYLOAD_SIZE_BITS;
    localparam int BEATS  = calc_beats(PW, DW);
    localparam int BYTES  = calc_bytes(DW);
    localparam int ALIGN  = $clog2(PW / 8);
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic              adv, cap;
    logic              gnt_vld;
    logic [IDX_W-1:0]  gnt_idx, gnt_q;
    logic [AW-1:0]     sel_addr;
    logic [PW-1:0]     sel_wdata;
    logic              sel_rw;
    logic [PW-1:0]     wsh;

    mcse_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_go),
        .upd     (state == ST_DONE),
        .upd_idx (gnt_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rw    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*PW +: PW];
                sel_rw    = req_rw[i];
            end
        end
    end

    // beat counts address phases issued; the data phase in flight is always beat-1.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        adv       = 1'b0;
        cap       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_nxt = ST_ADDR;
                    beat_nxt  = '0;
                end
            end
            ST_ADDR: begin
                if (I_hready) begin
                    adv       = 1'b1;
                    beat_nxt  = BEAT_W'(1);
                    state_nxt = (BEATS == 1) ? ST_LAST : ST_BURST;
                end
            end
            ST_BURST, ST_LAST: begin
                if (I_hresp == pAHB_HRESP_WIDTH'(HRESP_ERROR) && !I_hready) begin
                    state_nxt = ST_ERR;
                end else if (I_hready) begin
                    cap = 1'b1;
                    if (state == ST_BURST) begin
                        adv       = 1'b1;
                        beat_nxt  = beat + 1'b1;
                        state_nxt = (beat_nxt == BEAT_W'(BEATS)) ? ST_LAST : ST_BURST;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_ERR: begin
                if (I_hready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            wsh       <= '0;
            O_haddr   <= '0;
            O_htrans  <= pAHB_TRANS_WIDTH'(HTRANS_IDLE);
            O_hwdata  <= '0;
            O_hwrite  <= 1'b0;
            req_done  <= '0;
            req_err   <= '0;
            req_rdata <= '0;
        end else begin
            if (state == ST_IDLE && gnt_vld) begin
                gnt_q    <= gnt_idx;
                O_haddr  <= (sel_addr >> ALIGN) << ALIGN;
                O_hwrite <= sel_rw;
                wsh      <= sel_wdata;
            end else if (adv && state_nxt == ST_BURST) begin
                O_haddr <= O_haddr + AW'(BYTES);
            end

            // Write payload drains LSB-first; read beats enter at the top and shift down.
            if (adv) begin
                O_hwdata <= wsh[DW-1:0];
                wsh      <= wsh >> DW;
            end
            if (cap && !O_hwrite) begin
                req_rdata <= (req_rdata >> DW) | (PW'(I_hrdata) << (PW - DW));
            end

            case (state_nxt)
                ST_ADDR:  O_htrans <= pAHB_TRANS_WIDTH'(HTRANS_NONSEQ);
                ST_BURST: O_htrans <= pAHB_TRANS_WIDTH'(HTRANS_SEQ);
                default:  O_htrans <= pAHB_TRANS_WIDTH'(HTRANS_IDLE);
            endcase

            req_done <= '0;
            req_err  <= '0;
            if (state_nxt == ST_DONE) begin
                req_done <= N_REQ'(1) << gnt_q;
                req_err  <= (state == ST_ERR) ? (N_REQ'(1) << gnt_q) : '0;
            end
        end
    end

    assign O_hburst    = pAHB_BURST_WIDTH'(HBURST_INCR);
    assign O_hsize     = pAHB_SIZE_WIDTH'($clog2(BYTES));
    assign O_hprot     = pAHB_PROT_WIDTH'(HPROT_DEFAULT);
    assign O_hnonsec   = 1'b0;
    assign O_hmastlock = 1'b0;

endmodule

// File: tb/tb_mcse_bus_arbiter.sv
// Directed bench for mcse_bus_arbiter with an AHB slave model and beat/completion scoreboards.
// Inputs change and outputs are sampled on the falling edge.
module tb_mcse_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int P  = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_go, req_rw, req_done, req_err;
    logic [N*AW-1:0] req_addr;
    logic [N*P-1:0]  req_wdata;
    logic [P-1:0]    req_rdata;
    logic [DW-1:0]   I_hrdata;
    logic            I_hready;
    logic [1:0]      I_hresp;
    logic [AW-1:0]   O_haddr;
    logic [2:0]      O_hburst;
    logic            O_hmastlock;
    logic [3:0]      O_hprot;
    logic            O_hnonsec;
    logic [2:0]      O_hsize;
    logic [1:0]      O_htrans;
    logic [DW-1:0]   O_hwdata;
    logic            O_hwrite;

    always #5 clk = ~clk;

    mcse_bus_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_go      (req_go),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rw      (req_rw),
        .req_done    (req_done),
        .req_err     (req_err),
        .req_rdata   (req_rdata),
        .I_hrdata    (I_hrdata),
        .I_hready    (I_hready),
        .I_hresp     (I_hresp),
        .O_haddr     (O_haddr),
        .O_hburst    (O_hburst),
        .O_hmastlock (O_hmastlock),
        .O_hprot     (O_hprot),
        .O_hnonsec   (O_hnonsec),
        .O_hsize     (O_hsize),
        .O_htrans    (O_htrans),
        .O_hwdata    (O_hwdata),
        .O_hwrite    (O_hwrite)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int         ch;
        logic       err;
        logic       rd;
        logic [P-1:0] rdata;
        int         lat;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int checks = 0, errors = 0, cyc_cnt = 0;
    int t_go[N], remaining[N];
    logic          dp_vld = 1'b0, dp_wr = 1'b0;
    logic [AW-1:0] dp_addr = '0;
    int err_beat = -1, err_phase = 0, stall_beat = -1, stall_left = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_wdata;

    task automatic chk(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: check outputs, answer as the slave, then retire beats that complete.
    task automatic cyc();
        done_t d;
        beat_t b;
        int    ch;
        logic  stall;
        @(negedge clk);
        cyc_cnt++;
        if (req_done !== '0) begin
            ch = req_done[1] ? 1 : 0;
            if (done_q.size() == 0) begin
                chk("unexpected_done", P'(done_q.size()), P'(1));
            end else begin
                d = done_q.pop_front();
                chk("done_onehot", P'(req_done), P'(1) << d.ch);
                chk("done_err", P'(req_err), d.err ? (P'(1) << d.ch) : P'(0));
                if (d.rd) chk("rdata", req_rdata, d.rdata);
                if (d.lat > 0) chk("latency", P'(cyc_cnt - t_go[d.ch]), P'(d.lat));
            end
            remaining[ch]--;
            if (remaining[ch] <= 0) begin
                remaining[ch] = 0;
                req_go[ch]    = 1'b0;
            end
        end
        if (O_htrans != 2'b00)
            chk("htrans", P'(O_htrans), P'((O_haddr[4:0] == 5'd0) ? 2'b10 : 2'b11));

        stall = 1'b0;
        if (err_phase == 1) begin
            chk("htrans_idle_after_err", P'(O_htrans), P'(2'b00));
            I_hready  = 1'b1;
            I_hresp   = 2'b01;
            err_phase = 2;
            dp_vld    = 1'b0;
        end else if (dp_vld && int'(dp_addr[4:2]) == err_beat && err_phase == 0) begin
            I_hready  = 1'b0;
            I_hresp   = 2'b01;
            err_phase = 1;
        end else if (dp_vld && int'(dp_addr[4:2]) == stall_beat && stall_left > 0) begin
            I_hready = 1'b0;
            I_hresp  = 2'b00;
            stall_left--;
            stall = 1'b1;
            if (prev_stall) begin
                chk("stall_haddr", P'(O_haddr), P'(held_addr));
                chk("stall_hwdata", P'(O_hwdata), P'(held_wdata));
            end
            held_addr  = O_haddr;
            held_wdata = O_hwdata;
        end else begin
            I_hready = 1'b1;
            I_hresp  = 2'b00;
        end
        prev_stall = stall;
        I_hrdata = (dp_vld && !dp_wr) ? 32'hA0 + 32'(dp_addr[4:2]) : 32'hDEAD_BEEF;

        if (I_hready) begin
            if (dp_vld) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", P'(beat_q.size()), P'(1));
                end else begin
                    b = beat_q.pop_front();
                    chk("haddr", P'(dp_addr), P'(b.addr));
                    chk("hwrite", P'(dp_wr), P'(b.wr));
                    if (b.wr) chk("hwdata", P'(O_hwdata), P'(b.data));
                end
            end
            dp_vld  = O_htrans[1];
            dp_addr = O_haddr;
            dp_wr   = O_hwrite;
        end
    endtask

    task automatic push_txn(input int ch, input logic rw, input logic [AW-1:0] addr,
                            input logic [P-1:0] wdata, input int nb, input logic err, input int lat);
        beat_t         b;
        done_t         d;
        logic [AW-1:0] base;
        base = {addr[AW-1:5], 5'd0};
        for (int k = 0; k < nb; k++) begin
            b.addr = base + AW'(4 * k);
            b.wr   = rw;
            b.data = wdata[32*k +: 32];
            beat_q.push_back(b);
        end
        d.ch  = ch;
        d.err = err;
        d.rd  = !rw && !err;
        d.rdata = '0;
        for (int k = 0; k < 8; k++) d.rdata[32*k +: 32] = 32'hA0 + 32'(k);
        d.lat = lat;
        done_q.push_back(d);
    endtask

    task automatic start(input int ch, input logic rw, input logic [AW-1:0] addr,
                         input logic [P-1:0] wdata, input int n);
        req_addr[ch*AW +: AW] = addr;
        req_wdata[ch*P +: P]  = wdata;
        req_rw[ch]            = rw;
        req_go[ch]            = 1'b1;
        remaining[ch]         = n;
        t_go[ch]              = cyc_cnt;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((done_q.size() > 0 || req_go != '0) && n < max) begin
            cyc();
            n++;
        end
        chk("drain_in_time", P'(n < max), P'(1));
        cyc();
        chk("done_low_after", P'(req_done), P'(0));
        chk("beats_consumed", P'(beat_q.size()), P'(0));
    endtask

    task automatic check_reset_values();
        chk("rst_htrans", P'(O_htrans), P'(2'b00));
        chk("rst_haddr", P'(O_haddr), P'(0));
        chk("rst_hwdata", P'(O_hwdata), P'(0));
        chk("rst_hwrite", P'(O_hwrite), P'(0));
        chk("rst_hmastlock", P'(O_hmastlock), P'(0));
        chk("rst_hnonsec", P'(O_hnonsec), P'(0));
        chk("rst_hburst", P'(O_hburst), P'(3'b001));
        chk("rst_hsize", P'(O_hsize), P'(3'd2));
        chk("rst_hprot", P'(O_hprot), P'(4'b0011));
        chk("rst_req_done", P'(req_done), P'(0));
        chk("rst_req_err", P'(req_err), P'(0));
        chk("rst_req_rdata", req_rdata, P'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t exceeded limit 400000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [P-1:0] wp, wa, wb;
        int n;
        rst_n = 1'b0; req_go = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        I_hready = 1'b1; I_hresp = 2'b00; I_hrdata = '0;
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            t_go[i]      = 0;
        end
        for (int i = 0; i < 32; i++) wp[8*i +: 8] = 8'(i + 1);
        for (int k = 0; k < 8; k++) begin
            wa[32*k +: 32] = 32'hC000_0000 + 32'(k);
            wb[32*k +: 32] = 32'hD000_0000 + 32'(k);
        end
        repeat (3) cyc();
        check_reset_values();
        rst_n = 1'b1;
        cyc();

        // Single aligned write, no wait states
        push_txn(0, 1'b1, 32'h1000_0010, wp, 8, 1'b0, 10);
        start(0, 1'b1, 32'h1000_0010, wp, 1);
        drain(40);

        // Single read on channel 1
        push_txn(1, 1'b0, 32'h2000_0044, '0, 8, 1'b0, 10);
        start(1, 1'b0, 32'h2000_0044, '0, 1);
        drain(40);

        // Both channels requesting together: grants must alternate
        for (int t = 0; t < 3; t++) begin
            push_txn(0, 1'b1, 32'h3000_0000, wa, 8, 1'b0, 0);
            push_txn(1, 1'b1, 32'h3000_0100, wb, 8, 1'b0, 0);
        end
        start(0, 1'b1, 32'h3000_0000, wa, 3);
        start(1, 1'b1, 32'h3000_0100, wb, 3);
        drain(200);

        // Three wait states on the data phase of beat 4
        stall_beat = 4; stall_left = 3;
        push_txn(0, 1'b1, 32'h4000_0020, ~wp, 8, 1'b0, 13);
        start(0, 1'b1, 32'h4000_0020, ~wp, 1);
        drain(40);
        stall_beat = -1;

        // Two-cycle ERROR response on beat 2
        err_beat = 2; err_phase = 0;
        push_txn(1, 1'b1, 32'h5000_0000, wb, 2, 1'b1, 6);
        start(1, 1'b1, 32'h5000_0000, wb, 1);
        drain(40);
        err_beat = -1; err_phase = 0;

        // Reset while beat 5 is in its address phase
        push_txn(0, 1'b1, 32'h6000_0000, wa, 5, 1'b0, 0);
        void'(done_q.pop_back());
        start(0, 1'b1, 32'h6000_0000, wa, 1);
        n = 0;
        while (!(O_htrans != 2'b00 && O_haddr[4:2] == 3'd5) && n < 20) begin
            cyc();
            n++;
        end
        chk("reached_beat5", P'(n < 20), P'(1));
        rst_n = 1'b0;
        req_go = '0;
        remaining[0] = 0;
        dp_vld = 1'b0;
        cyc();
        check_reset_values();
        chk("rst_beats_consumed", P'(beat_q.size()), P'(0));
        beat_q.delete();
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (5) cyc();

        // Recovery after reset
        push_txn(1, 1'b0, 32'h7000_0000, '0, 8, 1'b0, 10);
        start(1, 1'b0, 32'h7000_0000, '0, 1);
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
